// File: rtl/lfsr_period_monitor.sv
// lfsr_period_monitor
//   Watches an N-bit Fibonacci LFSR after each seed load and measures the
//   number of shift steps until the seed recurs. Flags maximal length
//   (2^N-1), all-zero lockup and overrun, and holds the result until ack.
//
//   Handshake: result_valid rises when a run ends and stays high until the
//   consumer pulses ack (one cycle while result_valid=1) or a new start
//   re-arms the monitor; start always wins over ack.
//
//   Optional build macro LFSR_MON_SEQ_CHECK_EN: compare every COUNT sample
//   against the successor of the previous sample and flag a mismatch with
//   err_code 3. Without it no expected-state logic exists.
module lfsr_period_monitor #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] lfsr_data,
  input  logic         lfsr_done,
  input  logic         ack,
  output logic         busy,
  output logic         result_valid,
  output logic [N-1:0] period,
  output logic         maximal,
  output logic         err,
  output logic [1:0]   err_code
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ARM   = 3'd1;
  localparam logic [2:0] S_COUNT = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;
  localparam logic [2:0] S_ERROR = 3'd4;

  localparam logic [1:0] E_NONE    = 2'd0;
  localparam logic [1:0] E_LOCKUP  = 2'd1;
  localparam logic [1:0] E_TIMEOUT = 2'd2;
  localparam logic [1:0] E_SEQ     = 2'd3;

  // Last legal counter value before the period would exceed 2^N-1.
  localparam logic [N-1:0] CNT_LAST   = N'((1 << N) - 2);
  localparam logic [N-1:0] PERIOD_MAX = N'((1 << N) - 1);

  logic [2:0]   state;
  logic [2:0]   state_nxt;
  logic [N-1:0] cnt;
  logic [N-1:0] seed_q;
  logic [N-1:0] cnt_inc;

  logic         data_zero;
  logic         seed_hit;
  logic         cnt_last;
  logic         seq_bad;
  logic [1:0]   count_fail;

  assign cnt_inc   = cnt + N'(1);
  assign data_zero = (lfsr_data == '0);
  assign seed_hit  = lfsr_done && (lfsr_data == seed_q);
  assign cnt_last  = (cnt == CNT_LAST);

`ifdef LFSR_MON_SEQ_CHECK_EN
  // Feedback taps per width; only the low N bits of the mask are used.
  localparam logic [7:0] TAP_MASK =
    (N == 2) ? 8'b0000_0011 :
    (N == 3) ? 8'b0000_0110 :
    (N == 4) ? 8'b0000_1100 :
    (N == 5) ? 8'b0001_0100 :
    (N == 6) ? 8'b0011_0000 :
    (N == 7) ? 8'b0110_0000 :
               8'b1011_1000;

  logic [N-1:0] prev_q;
  logic [N-1:0] exp_data;

  assign exp_data = {prev_q[N-2:0], ^(prev_q & TAP_MASK[N-1:0])};
  assign seq_bad  = (state == S_COUNT) && (lfsr_data != exp_data);

  // Previous sample: the seed in ARM, then every COUNT sample.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_q <= '0;
    end else if ((state == S_ARM) || (state == S_COUNT)) begin
      prev_q <= lfsr_data;
    end
  end
`else
  assign seq_bad = 1'b0;
`endif

  // Error code a COUNT sample would raise, in priority order; a seed hit
  // pre-empts the overrun check.
  always_comb begin
    count_fail = E_NONE;
    if (data_zero) begin
      count_fail = E_LOCKUP;
    end else if (seq_bad) begin
      count_fail = E_SEQ;
    end else if (!seed_hit && cnt_last) begin
      count_fail = E_TIMEOUT;
    end
  end

  // Next-state decision; start re-arms from any state.
  always_comb begin
    state_nxt = state;
    if (start) begin
      state_nxt = S_ARM;
    end else begin
      case (state)
        S_IDLE:  state_nxt = S_IDLE;
        S_ARM:   state_nxt = data_zero ? S_ERROR : S_COUNT;
        S_COUNT: begin
          if (count_fail != E_NONE) begin
            state_nxt = S_ERROR;
          end else if (seed_hit) begin
            state_nxt = S_DONE;
          end
        end
        S_DONE, S_ERROR: begin
          if (ack) begin
            state_nxt = S_IDLE;
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Run bookkeeping (seed capture, step counter) and result registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt      <= '0;
      seed_q   <= '0;
      period   <= '0;
      maximal  <= 1'b0;
      err      <= 1'b0;
      err_code <= E_NONE;
    end else if (start) begin
      period   <= '0;
      maximal  <= 1'b0;
      err      <= 1'b0;
      err_code <= E_NONE;
    end else begin
      case (state)
        S_ARM: begin
          seed_q <= lfsr_data;
          cnt    <= '0;
          if (data_zero) begin
            err      <= 1'b1;
            err_code <= E_LOCKUP;
          end
        end
        S_COUNT: begin
          if (count_fail != E_NONE) begin
            err      <= 1'b1;
            err_code <= count_fail;
          end else if (seed_hit) begin
            period  <= cnt_inc;
            maximal <= (cnt_inc == PERIOD_MAX);
          end else begin
            cnt <= cnt_inc;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign busy         = (state == S_ARM) || (state == S_COUNT);
  assign result_valid = (state == S_DONE) || (state == S_ERROR);

endmodule

// File: tb/tb_lfsr_period_monitor.sv
// tb_lfsr_period_monitor
//   Drives lfsr_period_monitor (N=4) with a behavioural 4-bit LFSR
//   (x^4+x^3+1) plus directed and random runs. A sample-history model
//   predicts all outputs each cycle; literal checks pin key results.
//   Honours LFSR_MON_SEQ_CHECK_EN when it is defined.
module tb_lfsr_period_monitor;

  localparam int N = 4;
`ifdef LFSR_MON_SEQ_CHECK_EN
  localparam bit SEQ_EN = 1'b1;
`else
  localparam bit SEQ_EN = 1'b0;
`endif

  logic         clk;
  logic         reset;
  logic         start;
  logic [N-1:0] lfsr_data;
  logic         lfsr_done;
  logic         ack;
  logic         busy;
  logic         result_valid;
  logic [N-1:0] period;
  logic         maximal;
  logic         err;
  logic [1:0]   err_code;

  int n_vec = 0;
  int n_bad = 0;
  int edge_cnt = 0;
  logic [N-1:0] cur_seed = '0;

  lfsr_period_monitor #(.N(N)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .lfsr_data    (lfsr_data),
    .lfsr_done    (lfsr_done),
    .ack          (ack),
    .busy         (busy),
    .result_valid (result_valid),
    .period       (period),
    .maximal      (maximal),
    .err          (err),
    .err_code     (err_code)
  );

  // ---------------- clock / watchdog ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1, "watchdog");
  end

  // ---------------- reference helpers ----------------
  function automatic logic [N-1:0] lfsr_next(input logic [N-1:0] x);
    int v;
    v = int'(x);
    return N'(((v * 2) % 16) + (((v / 8) ^ (v / 4)) % 2));
  endfunction

  // ---------------- behavioural model + scoreboard ----------------
  logic [9:0]   exp_q[$];
  logic [N-1:0] samples[$];
  bit           m_run = 1'b0;
  bit           m_valid = 1'b0;
  int           m_period = 0;
  bit           m_max = 1'b0;
  bit           m_err = 1'b0;
  int           m_code = 0;

  task automatic model_fail(input int code);
    m_err   = 1'b1;
    m_code  = code;
    m_run   = 1'b0;
    m_valid = 1'b1;
  endtask

  // Run outcome from the history of samples seen since start:
  // samples[0] is the seed, samples[k] is the state after k shifts.
  always @(posedge clk) begin
    int n;
    int k;
    if (reset) begin
      m_run = 0; m_valid = 0; m_period = 0; m_max = 0; m_err = 0; m_code = 0;
      samples.delete();
    end else if (start) begin
      m_run = 1; m_valid = 0; m_period = 0; m_max = 0; m_err = 0; m_code = 0;
      samples.delete();
    end else if (m_run) begin
      samples.push_back(lfsr_data);
      n = samples.size();
      k = n - 1;
      if (n == 1) begin
        if (samples[0] == '0) model_fail(1);
      end else if (samples[k] == '0) begin
        model_fail(1);
      end else if (SEQ_EN && (samples[k] != lfsr_next(samples[k-1]))) begin
        model_fail(3);
      end else if (lfsr_done && (samples[k] == samples[0])) begin
        m_period = k;
        m_max    = (k == 15);
        m_run    = 0;
        m_valid  = 1;
      end else if (k == 15) begin
        model_fail(2);
      end
    end else if (m_valid && ack) begin
      m_valid = 0;
    end
    exp_q.push_back({m_run, m_valid, 4'(m_period), m_max, m_err, 2'(m_code)});
  end

  // Compare every cycle, away from the active edge.
  always @(posedge clk) begin
    logic [9:0] e;
    logic [9:0] g;
    #2;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = {busy, result_valid, period, maximal, err, err_code};
      n_vec++;
      if (g !== e) begin
        n_bad++;
        $display("FAIL cycle_outputs t=%0t {busy,valid,period,max,err,code}: got %b expected %b",
                 $time, g, e);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Called at a negedge; returns at the negedge where the seed is on lfsr_data.
  task automatic do_start(input logic [N-1:0] s, input logic with_ack);
    start     = 1'b1;
    ack       = with_ack;
    lfsr_done = 1'b0;
    @(negedge clk);
    start     = 1'b0;
    ack       = 1'b0;
    lfsr_data = s;
    lfsr_done = 1'b1;
    cur_seed  = s;
    edge_cnt  = 1;
  endtask

  // Advance the LFSR each cycle until result_valid (bounded by budget).
  // glitch_at: step whose value is replaced by glitch_val; hold: freeze after it.
  task automatic run_until_valid(input int budget, input bit hold, input int glitch_at,
                                 input logic [N-1:0] glitch_val, input bit noisy,
                                 input int abort_at, output bit got);
    got = 1'b0;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      edge_cnt++;
      if (result_valid) begin
        ack = 1'b0;
        got = 1'b1;
        return;
      end
      if (i == abort_at) begin
        ack = 1'b0;
        return;
      end
      if (i == glitch_at) lfsr_data = glitch_val;
      else if (!(hold && (glitch_at != 0) && (i > glitch_at))) lfsr_data = lfsr_next(lfsr_data);
      lfsr_done = hold ? 1'b0 :
                  ((lfsr_data == cur_seed) || (noisy && ($urandom_range(0, 7) == 0)));
      ack = noisy && ($urandom_range(0, 3) == 0);
    end
    ack = 1'b0;
  endtask

  task automatic do_ack(input int delay);
    repeat (delay) @(negedge clk);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit got;
    bit pending;
    int kind;
    int abort_at;
    int glitch_at;
    bit hold;
    bit noisy;
    logic [N-1:0] seed;
    logic [N-1:0] gval;

    reset = 1'b1; start = 1'b0; ack = 1'b0; lfsr_data = '0; lfsr_done = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_valid", result_valid, 0);
    check("reset_period", period, 0);
    check("reset_err_code", err_code, 0);
    reset = 1'b0;
    @(negedge clk);

    // 1: maximal-length run from seed 0001.
    do_start(4'b0001, 1'b0);
    run_until_valid(40, 1'b0, 0, '0, 1'b0, 0, got);
    check("t1_valid", got, 1);
    check("t1_latency", edge_cnt, 17);
    check("t1_period", period, 15);
    check("t1_maximal", maximal, 1);
    check("t1_err", err, 0);
    do_ack(2);

    // 2: zero seed -> lockup straight after ARM, then ack.
    do_start(4'b0000, 1'b0);
    run_until_valid(40, 1'b0, 0, '0, 1'b0, 0, got);
    check("t2_valid", got, 1);
    check("t2_err", err, 1);
    check("t2_code", err_code, 1);
    check("t2_period", period, 0);
    do_ack(0);
    check("t2_valid_after_ack", result_valid, 0);
    check("t2_err_kept", err, 1);

    // 3: data stuck at 0101 after seed 0011 -> overrun.
    do_start(4'b0011, 1'b0);
    run_until_valid(40, 1'b1, 1, 4'b0101, 1'b0, 0, got);
    check("t3_valid", got, 1);
    check("t3_code", err_code, SEQ_EN ? 3 : 2);
    check("t3_latency", edge_cnt, SEQ_EN ? 3 : 17);
    do_ack(1);

    // 4: re-arm during COUNT at cnt=6, new seed 1000.
    do_start(4'b0001, 1'b0);
    run_until_valid(40, 1'b0, 0, '0, 1'b0, 7, got);
    check("t4_no_result", got, 0);
    check("t4_busy_before_rearm", busy, 1);
    do_start(4'b1000, 1'b0);
    run_until_valid(40, 1'b0, 0, '0, 1'b0, 0, got);
    check("t4_valid", got, 1);
    check("t4_period", period, 15);
    check("t4_latency", edge_cnt, 17);

    // 5: hold result 10 clocks, then ack+start together.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("t5_hold_valid", result_valid, 1);
      check("t5_hold_period", period, 15);
    end
    do_start(4'b0010, 1'b1);
    check("t5_valid_dropped", result_valid, 0);
    check("t5_busy", busy, 1);
    run_until_valid(40, 1'b0, 0, '0, 1'b0, 0, got);
    check("t5_period", period, 15);
    do_ack(0);

    // 6: third COUNT sample forced to 1111 and held.
    do_start(4'b0001, 1'b0);
    run_until_valid(40, 1'b1, 3, 4'b1111, 1'b0, 0, got);
    check("t6_valid", got, 1);
    check("t6_code", err_code, SEQ_EN ? 3 : 2);
    do_ack(0);

    // Random runs.
    pending = 1'b0;
    for (int r = 0; r < 60; r++) begin
      seed = ($urandom_range(0, 12) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
      kind = $urandom_range(0, 9);
      hold = (kind == 6);
      noisy = (kind >= 2) && (kind <= 4);
      glitch_at = 0;
      gval = 4'($urandom_range(0, 15));
      abort_at = 0;
      if (kind == 5 || kind == 6) glitch_at = $urandom_range(1, 12);
      if (kind == 9) begin glitch_at = $urandom_range(1, 12); gval = '0; end
      if (kind == 7 || kind == 8) abort_at = $urandom_range(1, 12);
      do_start(seed, pending);
      run_until_valid(40, hold, glitch_at, gval, noisy, abort_at, got);
      if (abort_at == 0) check("rand_run_ends", got, 1);
      if (!got && kind == 8) begin
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("rand_reset_busy", busy, 0);
        @(negedge clk);
      end
      if (got && ($urandom_range(0, 3) != 0)) begin
        pending = 1'b0;
        do_ack($urandom_range(0, 4));
      end else begin
        pending = got;
      end
    end

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
